// File: rtl/cpu_pkg.sv
// Shared CPU definitions: load-type codes, write-back source indices
// and a helper for sizing source-select fields.
package cpu_pkg;

    localparam logic [2:0] LD_WORD = 3'd0;
    localparam logic [2:0] LD_LB   = 3'd1;
    localparam logic [2:0] LD_LBU  = 3'd2;
    localparam logic [2:0] LD_LH   = 3'd3;
    localparam logic [2:0] LD_LHU  = 3'd4;

    localparam int SRC_MEM  = 0;
    localparam int SRC_ALU  = 1;
    localparam int SRC_PC8  = 2;
    localparam int SRC_HILO = 3;

    // Select field width; never narrower than one bit.
    function automatic int selWidth(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Sub-word load extension (lb/lbu/lh/lhu); purely combinational.
// Ports: rawData, ldType, addrLo in; extData out (DATA_W wide).
module load_extend
    import cpu_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rawData,
    input  logic [2:0]        ldType,
    input  logic [1:0]        addrLo,
    output logic [DATA_W-1:0] extData
);

    logic [7:0]  byteVal;
    logic [15:0] halfVal;

    // Halves ignore addrLo[0]; misaligned halves read the aligned lane.
    assign byteVal = rawData[{addrLo, 3'b000} +: 8];
    assign halfVal = rawData[{addrLo[1], 4'b0000} +: 16];

    always_comb begin
        extData = rawData;
        case (ldType)
            LD_LB:  extData = {{(DATA_W-8){byteVal[7]}}, byteVal};
            LD_LBU: extData = {{(DATA_W-8){1'b0}}, byteVal};
            LD_LH:  extData = {{(DATA_W-16){halfVal[15]}}, halfVal};
            LD_LHU: extData = {{(DATA_W-16){1'b0}}, halfVal};
            default: extData = rawData;
        endcase
    end

endmodule

// File: rtl/wb_result_stage.sv
// MEM/WB stage register with NSRC-way write-back select and load extension.
// Ports: clk, reset_n; m_* MEM-stage inputs; stall, flush; wb_* outputs.
module wb_result_stage
    import cpu_pkg::*;
#(
    parameter  int DATA_W = 32,
    parameter  int NSRC   = 4,
    parameter  int REG_AW = 5,
    localparam int SEL_W  = selWidth(NSRC)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   m_valid,
    input  logic [NSRC*DATA_W-1:0] m_src,
    input  logic [SEL_W-1:0]       m_sel,
    input  logic [2:0]             m_ld_type,
    input  logic [1:0]             m_addr_lo,
    input  logic                   m_we,
    input  logic [REG_AW-1:0]      m_waddr,
    input  logic                   stall,
    input  logic                   flush,
    output logic                   wb_valid,
    output logic                   wb_we,
    output logic [REG_AW-1:0]      wb_waddr,
    output logic [DATA_W-1:0]      wb_data,
    output logic                   wb_sel_err
);

    logic                   validQ;
    logic [NSRC*DATA_W-1:0] srcQ;
    logic [SEL_W-1:0]       selQ;
    logic [2:0]             ldTypeQ;
    logic [1:0]             addrLoQ;
    logic                   weQ;
    logic [REG_AW-1:0]      waddrQ;
    logic                   selErrQ;

    logic                   selErrIn;
    logic [DATA_W-1:0]      muxData;
    logic [DATA_W-1:0]      extData;

    assign selErrIn = {1'b0, m_sel} >= (SEL_W+1)'(NSRC);

    // A flush only needs to kill the side-effect bits; the payload
    // simply holds.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            validQ  <= 1'b0;
            srcQ    <= '0;
            selQ    <= '0;
            ldTypeQ <= LD_WORD;
            addrLoQ <= '0;
            weQ     <= 1'b0;
            waddrQ  <= '0;
            selErrQ <= 1'b0;
        end else if (flush) begin
            validQ  <= 1'b0;
            weQ     <= 1'b0;
            selErrQ <= 1'b0;
        end else if (!stall) begin
            validQ  <= m_valid;
            srcQ    <= m_src;
            selQ    <= m_sel;
            ldTypeQ <= m_ld_type;
            addrLoQ <= m_addr_lo;
            weQ     <= m_we;
            waddrQ  <= m_waddr;
            selErrQ <= selErrIn;
        end
    end

    // Out-of-range indices match no source and leave the data at zero.
    always_comb begin
        muxData = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (selQ == SEL_W'(i)) begin
                muxData = srcQ[i*DATA_W +: DATA_W];
            end
        end
    end

    load_extend #(
        .DATA_W (DATA_W)
    ) uExt (
        .rawData (srcQ[SRC_MEM*DATA_W +: DATA_W]),
        .ldType  (ldTypeQ),
        .addrLo  (addrLoQ),
        .extData (extData)
    );

    assign wb_data    = (selQ == SEL_W'(SRC_MEM)) ? extData : muxData;
    assign wb_valid   = validQ;
    assign wb_waddr   = waddrQ;
    assign wb_sel_err = selErrQ;
    assign wb_we      = validQ & weQ & (waddrQ != '0) & ~selErrQ;

endmodule

// File: tb/tb_wb_result_stage.sv
// Directed bench for wb_result_stage: default, NSRC=3 and 64-bit/NSRC=5
// instances share control inputs; each has its own source bus and select.
module tb_wb_result_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        m_valid;
    logic [2:0]  m_ld_type;
    logic [1:0]  m_addr_lo;
    logic        m_we;
    logic [4:0]  m_waddr;
    logic        stall;
    logic        flush;

    logic [127:0] srcA;
    logic [1:0]   selA;
    logic         vA, weA, errA;
    logic [4:0]   waA;
    logic [31:0]  dA;

    logic [95:0]  srcB;
    logic [1:0]   selB;
    logic         vB, weB, errB;
    logic [4:0]   waB;
    logic [31:0]  dB;

    logic [319:0] srcC;
    logic [2:0]   selC;
    logic         vC, weC, errC;
    logic [4:0]   waC;
    logic [63:0]  dC;

    logic [63:0]  vals [5];

    int testCount = 0;
    int failCount = 0;

    always #5 clk = ~clk;

    wb_result_stage #(.DATA_W(32), .NSRC(4), .REG_AW(5)) dutA (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_src(srcA),
        .m_sel(selA), .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
        .m_we(m_we), .m_waddr(m_waddr), .stall(stall), .flush(flush),
        .wb_valid(vA), .wb_we(weA), .wb_waddr(waA), .wb_data(dA),
        .wb_sel_err(errA)
    );

    wb_result_stage #(.DATA_W(32), .NSRC(3), .REG_AW(5)) dutB (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_src(srcB),
        .m_sel(selB), .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
        .m_we(m_we), .m_waddr(m_waddr), .stall(stall), .flush(flush),
        .wb_valid(vB), .wb_we(weB), .wb_waddr(waB), .wb_data(dB),
        .wb_sel_err(errB)
    );

    wb_result_stage #(.DATA_W(64), .NSRC(5), .REG_AW(5)) dutC (
        .clk(clk), .reset_n(reset_n), .m_valid(m_valid), .m_src(srcC),
        .m_sel(selC), .m_ld_type(m_ld_type), .m_addr_lo(m_addr_lo),
        .m_we(m_we), .m_waddr(m_waddr), .stall(stall), .flush(flush),
        .wb_valid(vC), .wb_we(weC), .wb_waddr(waC), .wb_data(dC),
        .wb_sel_err(errC)
    );

    task automatic checkVal(input string tag, input logic [63:0] got,
                            input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic loadCase(input string tag, input logic [2:0] lt,
                            input logic [1:0] al, input logic [31:0] exp);
        m_ld_type = lt;
        m_addr_lo = al;
        tick();
        checkVal(tag, 64'(dA), 64'(exp));
    endtask

    initial begin
        reset_n   = 1'b0;
        stall     = 1'b0;
        flush     = 1'b0;
        m_valid   = 1'b1;
        m_we      = 1'b1;
        m_waddr   = 5'd17;
        m_ld_type = LD_LH;
        m_addr_lo = 2'd3;
        srcA      = {4{32'hDEAD_BEEF}};
        selA      = 2'd1;
        srcB      = '0;
        selB      = 2'd0;
        srcC      = '0;
        selC      = 3'd0;
        tick();
        tick();
        checkVal("rst_valid", 64'(vA), 64'd0);
        checkVal("rst_we", 64'(weA), 64'd0);
        checkVal("rst_waddr", 64'(waA), 64'd0);
        checkVal("rst_data", 64'(dA), 64'd0);
        checkVal("rst_err", 64'(errA), 64'd0);
        checkVal("rst_dataC", dC, 64'd0);

        // Select ALU source.
        reset_n   = 1'b1;
        srcA      = {32'd0, 32'd0, 32'h1234_5678, 32'd0};
        selA      = 2'd1;
        m_ld_type = LD_WORD;
        m_addr_lo = 2'd0;
        m_waddr   = 5'd8;
        tick();
        checkVal("sel1_data", 64'(dA), 64'h1234_5678);
        checkVal("sel1_we", 64'(weA), 64'd1);
        checkVal("sel1_waddr", 64'(waA), 64'd8);
        checkVal("sel1_valid", 64'(vA), 64'd1);
        m_waddr = 5'd0;
        tick();
        checkVal("x0_we", 64'(weA), 64'd0);
        checkVal("x0_data", 64'(dA), 64'h1234_5678);
        m_waddr = 5'd9;
        m_valid = 1'b0;
        tick();
        checkVal("inv_we", 64'(weA), 64'd0);
        checkVal("inv_valid", 64'(vA), 64'd0);
        m_valid = 1'b1;

        // Loads from source 0.
        srcA = {32'h0BAD_0BAD, 32'h0, 32'h5555_5555, 32'h80FF_7F01};
        selA = 2'd0;
        loadCase("lb_a2", LD_LB, 2'd2, 32'hFFFF_FFFF);
        loadCase("lb_a1", LD_LB, 2'd1, 32'h0000_007F);
        loadCase("lbu_a3", LD_LBU, 2'd3, 32'h0000_0080);
        loadCase("lh_a3", LD_LH, 2'd3, 32'hFFFF_80FF);
        loadCase("lhu_a0", LD_LHU, 2'd0, 32'h0000_7F01);
        loadCase("lhu_a2", LD_LHU, 2'd2, 32'h0000_80FF);
        loadCase("ld6", 3'd6, 2'd1, 32'h80FF_7F01);
        loadCase("word", LD_WORD, 2'd2, 32'h80FF_7F01);
        // Extension must not touch non-memory sources.
        selA = 2'd1;
        loadCase("lb_alu", LD_LB, 2'd0, 32'h5555_5555);

        // Stall holds the register while inputs move.
        m_ld_type = LD_WORD;
        srcA      = {32'h0, 32'h0, 32'hAAAA_0001, 32'h0};
        m_waddr   = 5'd3;
        tick();
        checkVal("preStall", 64'(dA), 64'hAAAA_0001);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            srcA    = {4{32'h7777_0000 + 32'(i)}};
            selA    = 2'(i + 1);
            m_waddr = 5'(20 + i);
            m_we    = i[0];
            tick();
            checkVal("stall_data", 64'(dA), 64'hAAAA_0001);
            checkVal("stall_waddr", 64'(waA), 64'd3);
            checkVal("stall_we", 64'(weA), 64'd1);
        end
        flush = 1'b1;
        m_we  = 1'b1;
        tick();
        checkVal("flush_valid", 64'(vA), 64'd0);
        checkVal("flush_we", 64'(weA), 64'd0);
        stall   = 1'b0;
        flush   = 1'b0;
        srcA    = {32'h0, 32'hBBBB_0002, 32'h0, 32'h0};
        selA    = 2'd2;
        m_waddr = 5'd4;
        tick();
        checkVal("rel_data", 64'(dA), 64'hBBBB_0002);
        checkVal("rel_waddr", 64'(waA), 64'd4);
        checkVal("rel_we", 64'(weA), 64'd1);

        // Reset wins over stall.
        stall   = 1'b1;
        reset_n = 1'b0;
        tick();
        checkVal("rstStall_valid", 64'(vA), 64'd0);
        checkVal("rstStall_data", 64'(dA), 64'd0);
        reset_n = 1'b1;
        stall   = 1'b0;

        // Out-of-range select on the NSRC=3 instance.
        srcB    = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        selB    = 2'd3;
        m_waddr = 5'd5;
        tick();
        checkVal("err_flag", 64'(errB), 64'd1);
        checkVal("err_data", 64'(dB), 64'd0);
        checkVal("err_we", 64'(weB), 64'd0);
        checkVal("ok_err", 64'(errA), 64'd0);
        selB = 2'd2;
        tick();
        checkVal("ok_flagB", 64'(errB), 64'd0);
        checkVal("ok_dataB", 64'(dB), 64'h3333_3333);
        selB = 2'd3;
        tick();
        flush = 1'b1;
        tick();
        checkVal("flushErr", 64'(errB), 64'd0);
        flush = 1'b0;

        // 64-bit, five sources, one instruction per cycle.
        for (int i = 0; i < 5; i++) begin
            vals[i] = 64'hA5A5_0000_0000_0000 | (64'(i) << 40)
                    | 64'(32'h0F0F_0000 + 32'(i * 3 + 1));
            srcC[i*64 +: 64] = vals[i];
        end
        for (int i = 0; i < 5; i++) begin
            selC    = 3'(i);
            m_waddr = 5'(i + 10);
            tick();
            checkVal("sweep_data", dC, vals[i]);
            checkVal("sweep_waddr", 64'(waC), 64'(i + 10));
            checkVal("sweep_we", 64'(weC), 64'd1);
        end
        selC = 3'd5;
        tick();
        checkVal("sweep_err", 64'(errC), 64'd1);
        checkVal("sweep_errData", dC, 64'd0);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule

// File: doc/wb_result_stage.md
# wb_result_stage

MEM/WB pipeline register plus write-back result selection for the pipelined CPU. It generalises the two-way memory/ALU write-back select to `NSRC` selectable sources, with sub-word load extension for lb/lbu/lh/lhu. It also adds stall/flush control of the stage register. It sits between the data-memory stage and the register-file write port, and drives the register file and the forwarding unit.

## Interface
- `DATA_W`, 32, datapath width; must be a multiple of 16.
- `NSRC`, 4, number of write-back sources; `SEL_W = $clog2(NSRC)`, minimum 1.
- `REG_AW`, 5, register-file address width.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `m_valid` in 1: MEM-stage instruction valid.
- `m_src` in `NSRC*DATA_W`: flat source bus; source i occupies bits `[i*DATA_W +: DATA_W]`, and source 0 is memory read data.
- `m_sel` in `SEL_W`: source index.
- `m_ld_type` in 3: load type (WORD=0, LB=1, LBU=2, LH=3, LHU=4).
- `m_addr_lo` in 2: data address bits [1:0].
- `m_we` in 1: register write enable.
- `m_waddr` in `REG_AW`: destination register.
- `stall` in 1: hold the stage register.
- `flush` in 1: load a bubble.
- `wb_valid` out 1, `wb_we` out 1, `wb_waddr` out `REG_AW`, `wb_data` out `DATA_W`: write-back outputs.
- `wb_sel_err` out 1: `m_sel >= NSRC` was captured.

## Operation
- The stage register captures `m_valid`, all of `m_src`, `m_sel`, `m_ld_type`, `m_addr_lo`, `m_we` and `m_waddr` on each rising edge, subject to control priority.
- Control priority is `!reset_n` > `flush` > `stall` > normal capture.
  - Reset: all register fields become 0.
  - Flush: valid, we and sel_err are cleared; other fields are don't-care.
  - Stall: every field holds.
- All `wb_*` outputs are combinational functions of register contents only. There is no combinational path from `m_*`, `stall` or `flush` to the outputs.
- Selection: `wb_data` = source[sel]. If sel ≥ NSRC, `wb_data` = 0, `wb_we` = 0 and `wb_sel_err` = 1.
- Load extension applies only when sel == 0. Byte offset = `addr_lo`; half offset = `addr_lo[1]`, and `addr_lo[0]` is ignored for halves.
  - LB / LBU: select byte lane `addr_lo`, then sign- or zero-extend to `DATA_W`.
  - LH / LHU: select half lane `addr_lo[1]`, then sign- or zero-extend.
  - WORD and reserved codes 5–7: pass through unchanged.
- `wb_we` = reg.valid & reg.we & (reg.waddr != 0) & !sel_err.
- `wb_valid` = reg.valid, independent of we.

## Timing
- Latency: 1 cycle from `m_*` capture to `wb_*`.
- Throughput: 1 instruction per cycle when `stall` is low.
- Reset values: `wb_valid`=0, `wb_we`=0, `wb_waddr`=0, `wb_data`=0, `wb_sel_err`=0.
  - `wb_data` is 0 because sel=0, ld_type=WORD and source 0 is zero after reset.
- Reset asserted mid-stall clears the register on that edge.
- Stall released: capture resumes on the next edge.
- Flush and stall together: flush wins; the bubble is loaded.
- While stalled, the outputs repeat the held instruction every cycle. The register file must treat this as an idempotent rewrite.

## Structure
- Shared package `cpu_pkg` holds:
  - load-type constants `LD_WORD`, `LD_LB`, `LD_LBU`, `LD_LH`, `LD_LHU`;
  - source indices `SRC_MEM`=0, `SRC_ALU`=1, `SRC_PC8`=2, `SRC_HILO`=3.
- One sub-module, `load_extend`: parameter `DATA_W`; inputs raw data, `ld_type`, `addr_lo`; output extended data. It is purely combinational.
- Stage register and select logic live in `wb_result_stage`.

## Test plan
- Reset: hold `reset_n`=0 with arbitrary `m_*` for 2 cycles -> all `wb_*` = 0; release -> the first captured instruction appears one cycle later.
- Select: src1=0x1234_5678, sel=1, we=1, waddr=8 -> next cycle `wb_data`=0x1234_5678, `wb_we`=1, `wb_waddr`=8; the same with waddr=0 -> `wb_we`=0.
- Loads: src0=0x80FF_7F01.
  - LB, addr_lo=2 -> 0x0000_00FF sign-extended = 0xFFFF_FFFF.
  - LBU, addr_lo=3 -> 0x0000_0080.
  - LH, addr_lo=3 -> 0xFFFF_80FF.
  - LHU, addr_lo=0 -> 0x0000_7F01.
  - ld_type=6 -> 0x80FF_7F01.
- Stall/flush:
  - Stall for 3 cycles while `m_*` changes -> outputs constant.
  - Stall+flush together -> next cycle `wb_valid`=0, `wb_we`=0.
  - Release -> the new instruction is captured on the following edge.
- Range error: NSRC=3, sel=3, we=1 -> `wb_sel_err`=1, `wb_data`=0, `wb_we`=0.
- Parameter sweep: DATA_W=64, NSRC=5 -> back-to-back instructions cycling all sources, 1/cycle, each output matching its source one cycle after capture.
